regs_sb_file: RTL and testbench

//  Parametrised successor to the CPU register file: 2 async read ports, 1 sync write port,

---
 rtl/regs_sb_file.sv | 123 ++++++++++++
 tb/tb_regs_sb_file.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regs_sb_file.sv
// regs_sb_file: CPU register file with a per-register busy scoreboard.
//
// Two combinational read ports, one synchronous write port, r0 hardwired
// to zero. Each register carries a busy bit that is set when an
// instruction with that destination issues and cleared when its result is
// written back, so decode can detect load-use and multi-cycle hazards.
//
// Optional feature macro: REGS_BYPASS_EN
//   defined   - a write-back in flight this cycle is forwarded to a
//               matching read port (data = Wt_data, busy = 0).
//   undefined - reads see the register array only; a write becomes
//               visible the cycle after its clock edge.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   L_S, Wt_addr, Wt_data write-back port (write enable, address, data)
//   R_addr_A/B            read addresses
//   Set_busy, Busy_addr   issue port: mark Busy_addr as pending
//   rdata_A/B             read data (combinational)
//   busy_A/B              read address has an outstanding producer
//   busy_cnt              registered number of busy registers
module regs_sb_file #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              L_S,
    input  logic [ADDR_W-1:0] Wt_addr,
    input  logic [DATA_W-1:0] Wt_data,
    input  logic [ADDR_W-1:0] R_addr_A,
    input  logic [ADDR_W-1:0] R_addr_B,
    input  logic              Set_busy,
    input  logic [ADDR_W-1:0] Busy_addr,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic              busy_A,
    output logic              busy_B,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    logic wr_en, set_en, cnt_inc, cnt_dec;

    assign wr_en  = L_S && (Wt_addr != '0);
    assign set_en = Set_busy && (Busy_addr != '0);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[Wt_addr] = Wt_data;
            busy_d[Wt_addr] = 1'b0;
        end
        // Applied after the write so a same-address issue wins: the new
        // producer supersedes the one that is completing.
        if (set_en) begin
            busy_d[Busy_addr] = 1'b1;
        end
    end

    // Count tracks popcount(busy) incrementally: only a real 0->1 set or a
    // real 1->0 clear moves it. A clear that loses to a same-address set
    // does not count.
    always_comb begin
        cnt_inc    = set_en && !busy_q[Busy_addr];
        cnt_dec    = wr_en && busy_q[Wt_addr] && !(set_en && (Busy_addr == Wt_addr));
        busy_cnt_d = busy_cnt_q + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 0) ? '0 : RST_VAL;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

`ifdef REGS_BYPASS_EN
    // wr_en already excludes r0, so r0 is never forwarded.
    logic byp_a, byp_b;
    assign byp_a = wr_en && (Wt_addr == R_addr_A);
    assign byp_b = wr_en && (Wt_addr == R_addr_B);

    always_comb begin
        rdata_A = (R_addr_A == '0) ? '0 : regs_q[R_addr_A];
        rdata_B = (R_addr_B == '0) ? '0 : regs_q[R_addr_B];
        busy_A  = (R_addr_A != '0) && busy_q[R_addr_A];
        busy_B  = (R_addr_B != '0) && busy_q[R_addr_B];
        if (byp_a) begin
            rdata_A = Wt_data;
            busy_A  = 1'b0;
        end
        if (byp_b) begin
            rdata_B = Wt_data;
            busy_B  = 1'b0;
        end
    end
`else
    always_comb begin
        rdata_A = (R_addr_A == '0) ? '0 : regs_q[R_addr_A];
        rdata_B = (R_addr_B == '0) ? '0 : regs_q[R_addr_B];
        busy_A  = (R_addr_A != '0) && busy_q[R_addr_A];
        busy_B  = (R_addr_B != '0) && busy_q[R_addr_B];
    end
`endif

endmodule

// File: tb/tb_regs_sb_file.sv
// tb_regs_sb_file: self-checking bench for regs_sb_file (default parameters).
// Table rows drive one clock edge, then the write/issue inputs are dropped
// and the post-edge read ports and busy_cnt are compared with the row's
// expected values via a scoreboard queue. Hand sequences cover forwarding
// and the mid-operation reset.
module tb_regs_sb_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        L_S = 1'b0;
    logic [4:0]  Wt_addr = '0;
    logic [31:0] Wt_data = '0;
    logic [4:0]  R_addr_A = '0;
    logic [4:0]  R_addr_B = '0;
    logic        Set_busy = 1'b0;
    logic [4:0]  Busy_addr = '0;
    logic [31:0] rdata_A, rdata_B;
    logic        busy_A, busy_B;
    logic [5:0]  busy_cnt;

    regs_sb_file #(.DATA_W(32), .ADDR_W(5), .RST_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
        .R_addr_A(R_addr_A), .R_addr_B(R_addr_B), .Set_busy(Set_busy),
        .Busy_addr(Busy_addr), .rdata_A(rdata_A), .rdata_B(rdata_B),
        .busy_A(busy_A), .busy_B(busy_B), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ls;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        set;
        logic [4:0]  baddr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_ba;
        logic        exp_bb;
        logic [5:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " rdata_A"}, rdata_A, e.a);
            check({tag, " rdata_B"}, rdata_B, e.b);
            check({tag, " busy_A"}, {31'b0, busy_A}, {31'b0, e.ba});
            check({tag, " busy_B"}, {31'b0, busy_B}, {31'b0, e.bb});
            check({tag, " busy_cnt"}, {26'b0, busy_cnt}, {26'b0, e.cnt});
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        rst = v.rst; L_S = v.ls; Wt_addr = v.waddr; Wt_data = v.wdata;
        Set_busy = v.set; Busy_addr = v.baddr; R_addr_A = v.ra; R_addr_B = v.rb;
        e.a = v.exp_a; e.b = v.exp_b; e.ba = v.exp_ba; e.bb = v.exp_bb; e.cnt = v.exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; L_S = 1'b0; Set_busy = 1'b0;
        #1;
        pop_and_check($sformatf("vec%0d", idx));
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst ls  waddr wdata         set baddr ra  rb  exp_a         exp_b         ba bb cnt
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
        vecs[4]  = '{1'b0, 1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  5'd7,  5'd0,  32'h77,       32'h0,        1'b0, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  5'd3,  32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
        vecs[6]  = '{1'b0, 1'b1, 5'd4,  32'h44,       1'b1, 5'd3,  5'd3,  5'd4,  32'h0,        32'h44,       1'b1, 1'b0, 6'd1};
        vecs[7]  = '{1'b0, 1'b1, 5'd9,  32'h55,       1'b1, 5'd9,  5'd9,  5'd3,  32'h55,       32'h0,        1'b1, 1'b1, 6'd2};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h55,       32'h55,       1'b1, 1'b1, 6'd2};
        vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        32'h55,       1'b0, 1'b1, 6'd2};
        vecs[10] = '{1'b0, 1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  5'd3,  5'd9,  32'h33,       32'h55,       1'b0, 1'b1, 6'd1};
        vecs[11] = '{1'b0, 1'b1, 5'd20, 32'h2020,     1'b0, 5'd0,  5'd20, 5'd0,  32'h2020,     32'h0,        1'b0, 1'b0, 6'd1};
        vecs[12] = '{1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd31, 5'd9,  32'hFFFFFFFF, 32'h55,       1'b0, 1'b1, 6'd1};
        vecs[13] = '{1'b0, 1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  5'd9,  5'd31, 32'h99,       32'hFFFFFFFF, 1'b0, 1'b0, 6'd0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
        end

        // Forwarding: r12 busy, then write-back of r12 while port B reads it.
        Set_busy = 1'b1; Busy_addr = 5'd12;
        @(posedge clk);
        #1;
        Set_busy = 1'b0;
        L_S = 1'b1; Wt_addr = 5'd12; Wt_data = 32'hA5A5A5A5;
        R_addr_B = 5'd12; R_addr_A = 5'd0;
        #1;
`ifdef REGS_BYPASS_EN
        check("byp pre rdata_B", rdata_B, 32'hA5A5A5A5);
        check("byp pre busy_B", {31'b0, busy_B}, 32'd0);
`else
        check("byp pre rdata_B", rdata_B, 32'h0);
        check("byp pre busy_B", {31'b0, busy_B}, 32'd1);
`endif
        check("byp pre cnt", {26'b0, busy_cnt}, 32'd1);
        @(posedge clk);
        #1;
        L_S = 1'b0;
        #1;
        check("byp post rdata_B", rdata_B, 32'hA5A5A5A5);
        check("byp post busy_B", {31'b0, busy_B}, 32'd0);
        check("byp post cnt", {26'b0, busy_cnt}, 32'd0);

        // r0 is never forwarded.
        L_S = 1'b1; Wt_addr = 5'd0; Wt_data = 32'hBAD0BAD0; R_addr_A = 5'd0;
        #1;
        check("r0 nobyp rdata_A", rdata_A, 32'h0);
        @(posedge clk);
        #1;
        L_S = 1'b0;

        // Fill: write and issue every nonzero register on the same edge.
        for (int i = 1; i < 32; i++) begin
            L_S = 1'b1; Wt_addr = 5'(i); Wt_data = 32'h1000 + i;
            Set_busy = 1'b1; Busy_addr = 5'(i);
            @(posedge clk);
            #1;
        end
        L_S = 1'b0; Set_busy = 1'b0;
        R_addr_A = 5'd17; R_addr_B = 5'd31;
        #1;
        check("fill cnt max", {26'b0, busy_cnt}, 32'd31);
        check("fill rdata_A r17", rdata_A, 32'h1011);
        check("fill busy_A r17", {31'b0, busy_A}, 32'd1);
        check("fill rdata_B r31", rdata_B, 32'h101F);

        // Reset overrides write and issue in the same edge.
        rst = 1'b1; L_S = 1'b1; Wt_addr = 5'd5; Wt_data = 32'hCAFE;
        Set_busy = 1'b1; Busy_addr = 5'd6;
        @(posedge clk);
        #1;
        rst = 1'b0; L_S = 1'b0; Set_busy = 1'b0;
        #1;
        check("rst cnt", {26'b0, busy_cnt}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            R_addr_A = 5'(i);
            #1;
            check($sformatf("rst rdata r%0d", i), rdata_A, 32'h0);
            check($sformatf("rst busy r%0d", i), {31'b0, busy_A}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
